// File: rtl/sfr_ir_lcd_fifo_pkg.sv
// Shared definitions for the IR-capture / character-LCD SFR peripheral:
// register offsets from SFR_BASE, STATUS and CTRL bit positions, and the
// LCD write sequencer state encoding.
package sfr_ir_lcd_fifo_pkg;

   localparam logic [7:0] CTRL_OFS      = 8'h01;
   localparam logic [7:0] LCD_WDATA_OFS = 8'h03;
   localparam logic [7:0] STATUS_OFS    = 8'h0B;
   localparam logic [7:0] BYTE_SEL_OFS  = 8'h0C;
   localparam logic [7:0] IR_DATA_OFS   = 8'h0D;
   localparam logic [7:0] POP_OFS       = 8'h0E;

   localparam int unsigned ST_LCD_BUSY  = 0;
   localparam int unsigned ST_FIFO_NE   = 1;
   localparam int unsigned ST_FIFO_FULL = 2;
   localparam int unsigned ST_IR_OVF    = 3;
   localparam int unsigned ST_LCD_OVR   = 4;

   localparam int unsigned CTRL_RS_CLR  = 0;
   localparam int unsigned CTRL_RS_SET  = 1;
   localparam int unsigned CTRL_LCD_ON  = 4;
   localparam int unsigned CTRL_BLON    = 5;
   localparam int unsigned CTRL_IRQ_EN  = 6;
   localparam int unsigned CTRL_FLUSH   = 7;

   typedef enum logic [1:0] {
      LCD_IDLE  = 2'd0,
      LCD_SETUP = 2'd1,
      LCD_PULSE = 2'd2,
      LCD_HOLD  = 2'd3
   } lcd_state_t;

endpackage

// File: rtl/sfr_ir_lcd_fifo_fifo.sv
// ir_code_fifo: circular buffer of decoded IR codes.
//   clk/reset : falling-edge clock, async active-low reset
//   push/pop  : request strobes; push while full is refused, pop while empty ignored
//   flush     : empties the buffer, overrides push and pop
//   din/dout  : write data / combinational head entry
//   full/empty/count : occupancy (count is one bit wider than the pointers)
module ir_code_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop on the same edge frees the slot, so a push at full still lands.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(negedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sfr_ir_lcd_fifo.sv
// 8051 SFR peripheral: buffered IR code capture plus HD44780-style LCD port.
//   clk, reset        : falling-edge clock, async active-low reset
//   addr, D_IN, D_OUT : SFR address, write data, registered read data
//   sfr_wr, sfr_rd    : one-cycle SFR strobes
//   ir_valid, ir_code : decoded IR code input (byte 0 in bits [7:0])
//   irq               : level interrupt, registered
//   LCD_*             : LCD pins (LCD_RW tied low, write-only)
module sfr_ir_lcd_fifo
   import sfr_ir_lcd_fifo_pkg::*;
#(
   parameter logic [7:0]  SFR_BASE         = 8'hD0,
   parameter int unsigned IR_BYTES         = 4,
   parameter int unsigned FIFO_DEPTH       = 4,
   parameter int unsigned LCD_SETUP_CYCLES = 2,
   parameter int unsigned LCD_EN_CYCLES    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            addr,
   input  logic [7:0]            D_IN,
   output logic [7:0]            D_OUT,
   input  logic                  sfr_wr,
   input  logic                  sfr_rd,
   input  logic                  ir_valid,
   input  logic [8*IR_BYTES-1:0] ir_code,
   output logic                  irq,
   output logic                  LCD_BLON,
   output logic [7:0]            LCD_DATA,
   output logic                  LCD_EN,
   output logic                  LCD_ON,
   output logic                  LCD_RS,
   output logic                  LCD_RW
);

   localparam logic [7:0]  A_CTRL   = SFR_BASE + CTRL_OFS;
   localparam logic [7:0]  A_WDATA  = SFR_BASE + LCD_WDATA_OFS;
   localparam logic [7:0]  A_STATUS = SFR_BASE + STATUS_OFS;
   localparam logic [7:0]  A_BSEL   = SFR_BASE + BYTE_SEL_OFS;
   localparam logic [7:0]  A_IRDATA = SFR_BASE + IR_DATA_OFS;
   localparam logic [7:0]  A_POP    = SFR_BASE + POP_OFS;
   localparam int unsigned CNT_MAX  = (LCD_SETUP_CYCLES > LCD_EN_CYCLES) ? LCD_SETUP_CYCLES : LCD_EN_CYCLES;
   localparam int unsigned CW       = $clog2(CNT_MAX + 1);

   lcd_state_t                  state, state_n;
   logic [CW-1:0]               cnt, cnt_n;
   logic                        start;
   logic                        irq_en, rs_tgt, rs_tgt_n;
   logic [2:0]                  byte_sel;
   logic                        ir_ovf, lcd_ovr;
   logic                        wr_ctrl, wr_wdata, wr_bsel, wr_pop, rd_status, flush;
   logic                        ovf_set, ovr_set, busy;
   logic                        fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [8*IR_BYTES-1:0]       fifo_head;
   logic [7:0]                  status, ir_byte, rd_val;
   logic                        rd_hit;

   assign LCD_RW    = 1'b0;
   assign wr_ctrl   = sfr_wr && (addr == A_CTRL);
   assign wr_wdata  = sfr_wr && (addr == A_WDATA);
   assign wr_bsel   = sfr_wr && (addr == A_BSEL);
   assign wr_pop    = sfr_wr && (addr == A_POP);
   assign rd_status = sfr_rd && (addr == A_STATUS);
   assign flush     = wr_ctrl && D_IN[CTRL_FLUSH];
   assign busy      = (state != LCD_IDLE);
   // Full implies non-empty, so a concurrent POP always makes room.
   assign ovf_set   = ir_valid && fifo_full && !wr_pop && !flush;
   assign ovr_set   = wr_wdata && busy;

   ir_code_fifo #(
      .WIDTH (8*IR_BYTES),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (ir_valid),
      .pop   (wr_pop),
      .flush (flush),
      .din   (ir_code),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      status = '0;
      status[ST_LCD_BUSY]  = busy;
      status[ST_FIFO_NE]   = (fifo_count != '0);
      status[ST_FIFO_FULL] = fifo_full;
      status[ST_IR_OVF]    = ir_ovf;
      status[ST_LCD_OVR]   = lcd_ovr;
   end

   always_comb begin
      ir_byte = '0;
      if (!fifo_empty && ({29'd0, byte_sel} < IR_BYTES))
         ir_byte = fifo_head[{byte_sel, 3'b000} +: 8];
   end

   always_comb begin
      rd_hit = 1'b0;
      rd_val = '0;
      if (sfr_rd) begin
         rd_hit = 1'b1;
         case (addr)
            A_CTRL:   rd_val = {1'b0, irq_en, LCD_BLON, LCD_ON, 4'b0000};
            A_STATUS: rd_val = status;
            A_BSEL:   rd_val = {5'd0, byte_sel};
            A_IRDATA: rd_val = ir_byte;
            default:  rd_hit = 1'b0;
         endcase
      end
   end

   // RS request from CTRL: set has priority over clear, otherwise hold.
   always_comb begin
      rs_tgt_n = rs_tgt;
      if (wr_ctrl) begin
         if (D_IN[CTRL_RS_SET])      rs_tgt_n = 1'b1;
         else if (D_IN[CTRL_RS_CLR]) rs_tgt_n = 1'b0;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      start   = 1'b0;
      case (state)
         LCD_IDLE: begin
            if (wr_wdata) begin
               state_n = LCD_SETUP;
               cnt_n   = CW'(LCD_SETUP_CYCLES - 1);
               start   = 1'b1;
            end
         end
         LCD_SETUP: begin
            if (cnt == '0) begin
               state_n = LCD_PULSE;
               cnt_n   = CW'(LCD_EN_CYCLES - 1);
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         LCD_PULSE: begin
            if (cnt == '0) state_n = LCD_HOLD;
            else           cnt_n   = cnt - 1'b1;
         end
         LCD_HOLD: state_n = LCD_IDLE;
         default:  state_n = LCD_IDLE;
      endcase
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state    <= LCD_IDLE;
         cnt      <= '0;
         LCD_EN   <= 1'b0;
         LCD_DATA <= '0;
         LCD_ON   <= 1'b0;
         LCD_BLON <= 1'b0;
         LCD_RS   <= 1'b0;
         irq_en   <= 1'b0;
         rs_tgt   <= 1'b0;
         byte_sel <= '0;
         ir_ovf   <= 1'b0;
         lcd_ovr  <= 1'b0;
         irq      <= 1'b0;
         D_OUT    <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         LCD_EN <= (state_n == LCD_PULSE);
         if (start) LCD_DATA <= D_IN;
         if (wr_ctrl) begin
            LCD_ON   <= D_IN[CTRL_LCD_ON];
            LCD_BLON <= D_IN[CTRL_BLON];
            irq_en   <= D_IN[CTRL_IRQ_EN];
         end
         // RS is only driven to the pin between transfers; a mid-transfer
         // request waits in rs_tgt.
         rs_tgt <= rs_tgt_n;
         if (state == LCD_IDLE) LCD_RS <= rs_tgt_n;
         if (wr_bsel) byte_sel <= D_IN[2:0];
         // Setting events win over the read-to-clear.
         ir_ovf  <= ovf_set | (ir_ovf & ~rd_status & ~flush);
         lcd_ovr <= ovr_set | (lcd_ovr & ~rd_status);
         irq     <= irq_en & ((fifo_count != '0) | ir_ovf);
         if (rd_hit) D_OUT <= rd_val;
      end
   end

endmodule

// File: tb/tb_sfr_ir_lcd_fifo.sv
module tb_sfr_ir_lcd_fifo;

   localparam logic [7:0] A_CTRL   = 8'hD1;
   localparam logic [7:0] A_WDATA  = 8'hD3;
   localparam logic [7:0] A_STATUS = 8'hDB;
   localparam logic [7:0] A_BSEL   = 8'hDC;
   localparam logic [7:0] A_IRDATA = 8'hDD;
   localparam logic [7:0] A_POP    = 8'hDE;
   localparam logic [7:0] A_UNMAP  = 8'hD2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  addr = '0;
   logic [7:0]  D_IN = '0;
   logic [7:0]  D_OUT;
   logic        sfr_wr = 1'b0;
   logic        sfr_rd = 1'b0;
   logic        ir_valid = 1'b0;
   logic [31:0] ir_code = '0;
   logic        irq, LCD_BLON, LCD_EN, LCD_ON, LCD_RS, LCD_RW;
   logic [7:0]  LCD_DATA;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sfr_ir_lcd_fifo #(
      .SFR_BASE(8'hD0), .IR_BYTES(4), .FIFO_DEPTH(4),
      .LCD_SETUP_CYCLES(2), .LCD_EN_CYCLES(32)
   ) dut (
      .clk(clk), .reset(reset), .addr(addr), .D_IN(D_IN), .D_OUT(D_OUT),
      .sfr_wr(sfr_wr), .sfr_rd(sfr_rd), .ir_valid(ir_valid), .ir_code(ir_code),
      .irq(irq), .LCD_BLON(LCD_BLON), .LCD_DATA(LCD_DATA), .LCD_EN(LCD_EN),
      .LCD_ON(LCD_ON), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); addr = a; D_IN = d; sfr_wr = 1'b1;
      @(negedge clk); #1; sfr_wr = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      @(posedge clk); addr = a; sfr_rd = 1'b1;
      @(negedge clk); #1; sfr_rd = 1'b0; d = D_OUT;
   endtask

   task automatic push(input logic [31:0] c);
      @(posedge clk); ir_code = c; ir_valid = 1'b1;
      @(negedge clk); #1; ir_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset = 1'b0;
      repeat (2) @(negedge clk); #1;
      checks++; if ({D_OUT, irq, LCD_BLON, LCD_DATA, LCD_EN, LCD_ON, LCD_RS, LCD_RW} !== 22'd0) begin
         errors++; $display("FAIL reset_outputs: got %h required 0", {D_OUT, irq, LCD_BLON, LCD_DATA, LCD_EN, LCD_ON, LCD_RS, LCD_RW}); end
      @(posedge clk); reset = 1'b1;
      rd(A_STATUS, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status: got %h required 00", d); end
      rd(A_CTRL, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h required 00", d); end
      rd(A_BSEL, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_bytesel: got %h required 00", d); end
   endtask

   task automatic test_ctrl();
      logic [7:0] d;
      wr(A_CTRL, 8'h32);
      checks++; if ({LCD_ON, LCD_BLON, LCD_RS} !== 3'b111) begin
         errors++; $display("FAIL ctrl_32: on/blon/rs got %b required 111", {LCD_ON, LCD_BLON, LCD_RS}); end
      wr(A_CTRL, 8'h31);
      checks++; if ({LCD_ON, LCD_BLON, LCD_RS} !== 3'b110) begin
         errors++; $display("FAIL ctrl_31: on/blon/rs got %b required 110", {LCD_ON, LCD_BLON, LCD_RS}); end
      rd(A_CTRL, d);
      checks++; if (d !== 8'h30) begin errors++; $display("FAIL ctrl_read: got %h required 30", d); end
      wr(A_UNMAP, 8'hFF);
      checks++; if ({LCD_ON, LCD_BLON, LCD_RS, LCD_EN} !== 4'b1100) begin
         errors++; $display("FAIL unmapped_write: on/blon/rs/en got %b required 1100", {LCD_ON, LCD_BLON, LCD_RS, LCD_EN}); end
      rd(A_UNMAP, d);
      checks++; if (d !== 8'h30) begin errors++; $display("FAIL unmapped_read: D_OUT got %h required 30 (held)", d); end
   endtask

   // Full transfer: EN low after edges 0..1, high after edges 2..33, low after;
   // STATUS read on edge k reflects busy from before that edge (busy through k=35).
   task automatic test_lcd_transfer(input logic [7:0] v);
      logic       exp_en;
      logic [7:0] exp_st;
      wr(A_WDATA, v);
      checks++; if (LCD_DATA !== v || LCD_EN !== 1'b0) begin
         errors++; $display("FAIL lcd_start: data %h en %b required %h 0", LCD_DATA, LCD_EN, v); end
      addr = A_STATUS; sfr_rd = 1'b1;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk); #1;
         exp_en = (k >= 2 && k <= 33);
         exp_st = {7'd0, (k <= 35)};
         checks++; if (LCD_EN !== exp_en) begin
            errors++; $display("FAIL lcd_en_cycle%0d: got %b required %b", k, LCD_EN, exp_en); end
         checks++; if (D_OUT !== exp_st) begin
            errors++; $display("FAIL lcd_busy_cycle%0d: status got %h required %h", k, D_OUT, exp_st); end
      end
      sfr_rd = 1'b0;
      checks++; if (LCD_DATA !== v) begin errors++; $display("FAIL lcd_data_end: got %h required %h", LCD_DATA, v); end
   endtask

   task automatic test_lcd_overrun();
      logic [7:0] d;
      int n;
      wr(A_WDATA, 8'h41);
      repeat (5) @(negedge clk); #1;
      checks++; if (LCD_EN !== 1'b1) begin errors++; $display("FAIL ovr_in_pulse: EN got %b required 1", LCD_EN); end
      wr(A_WDATA, 8'h42);
      checks++; if (LCD_DATA !== 8'h41) begin errors++; $display("FAIL ovr_data_kept: got %h required 41", LCD_DATA); end
      wr(A_CTRL, 8'h32);
      checks++; if ({LCD_ON, LCD_BLON, LCD_RS} !== 3'b110) begin
         errors++; $display("FAIL rs_deferred: on/blon/rs got %b required 110", {LCD_ON, LCD_BLON, LCD_RS}); end
      rd(A_STATUS, d);
      checks++; if (d !== 8'h11) begin errors++; $display("FAIL ovr_status: got %h required 11", d); end
      rd(A_STATUS, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL ovr_cleared: got %h required 01", d); end
      addr = A_STATUS; sfr_rd = 1'b1; n = 0;
      do begin @(negedge clk); #1; n++; end while (D_OUT[0] === 1'b1 && n < 100);
      sfr_rd = 1'b0;
      checks++; if (D_OUT !== 8'h00) begin errors++; $display("FAIL ovr_idle: status got %h required 00 after %0d cycles", D_OUT, n); end
      checks++; if (LCD_RS !== 1'b1) begin errors++; $display("FAIL rs_applied_idle: got %b required 1", LCD_RS); end
   endtask

   task automatic test_fifo();
      logic [7:0]  d;
      logic [31:0] codes [5];
      logic [7:0]  exp;
      codes = '{32'h11223344, 32'h22334455, 32'h33445566, 32'h44556677, 32'h55667788};
      for (int i = 0; i < 5; i++) push(codes[i]);
      rd(A_STATUS, d);
      checks++; if (d !== 8'h0E) begin errors++; $display("FAIL fifo_full_ovf: status got %h required 0E", d); end
      rd(A_STATUS, d);
      checks++; if (d !== 8'h06) begin errors++; $display("FAIL fifo_ovf_clear: status got %h required 06", d); end
      wr(A_BSEL, 8'h03); rd(A_IRDATA, d);
      checks++; if (d !== 8'h11) begin errors++; $display("FAIL irdata_b3: got %h required 11", d); end
      wr(A_BSEL, 8'h00); rd(A_IRDATA, d);
      checks++; if (d !== 8'h44) begin errors++; $display("FAIL irdata_b0: got %h required 44", d); end
      wr(A_BSEL, 8'h05); rd(A_BSEL, d);
      checks++; if (d !== 8'h05) begin errors++; $display("FAIL bytesel_read: got %h required 05", d); end
      rd(A_IRDATA, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL irdata_sel_oob: got %h required 00", d); end
      wr(A_BSEL, 8'h00);
      for (int i = 1; i <= 3; i++) begin
         wr(A_POP, 8'h00); rd(A_IRDATA, d);
         exp = codes[i][7:0];
         checks++; if (d !== exp) begin errors++; $display("FAIL pop%0d_head: got %h required %h", i, d, exp); end
      end
      wr(A_POP, 8'h00); rd(A_STATUS, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL fifo_empty: status got %h required 00", d); end
      rd(A_IRDATA, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL irdata_empty: got %h required 00", d); end
      wr(A_POP, 8'h00);
      push(32'hCAFEF00D);
      rd(A_STATUS, d);
      checks++; if (d !== 8'h02) begin errors++; $display("FAIL pop_empty_ignored: status got %h required 02", d); end
      rd(A_IRDATA, d);
      checks++; if (d !== 8'h0D) begin errors++; $display("FAIL push_after_empty_pop: got %h required 0D", d); end
      wr(A_CTRL, 8'hB0); rd(A_STATUS, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL flush: status got %h required 00", d); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      for (int i = 1; i <= 4; i++) push(32'hA0A0A0A0 | 32'(i));
      rd(A_STATUS, d);
      checks++; if (d !== 8'h06) begin errors++; $display("FAIL b2b_full: status got %h required 06", d); end
      @(posedge clk); addr = A_POP; D_IN = 8'h00; sfr_wr = 1'b1; ir_code = 32'hB5B5B5B5; ir_valid = 1'b1;
      @(negedge clk); #1; sfr_wr = 1'b0; ir_valid = 1'b0;
      rd(A_STATUS, d);
      checks++; if (d !== 8'h06) begin errors++; $display("FAIL b2b_no_ovf: status got %h required 06", d); end
      rd(A_IRDATA, d);
      checks++; if (d !== 8'hA2) begin errors++; $display("FAIL b2b_head: got %h required A2", d); end
      repeat (3) wr(A_POP, 8'h00);
      rd(A_IRDATA, d);
      checks++; if (d !== 8'hB5) begin errors++; $display("FAIL b2b_tail: got %h required B5", d); end
      wr(A_POP, 8'h00); rd(A_STATUS, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL b2b_drain: status got %h required 00", d); end
   endtask

   task automatic test_irq();
      logic [7:0] d;
      wr(A_CTRL, 8'h40);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b required 0", irq); end
      push(32'h000000E1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b required 0 on push edge", irq); end
      @(negedge clk); #1;
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b required 1", irq); end
      @(posedge clk); addr = A_CTRL; D_IN = 8'hC0; sfr_wr = 1'b1; ir_code = 32'h000000E2; ir_valid = 1'b1;
      @(negedge clk); #1; sfr_wr = 1'b0; ir_valid = 1'b0;
      @(negedge clk); #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_flush: got %b required 0", irq); end
      rd(A_STATUS, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL flush_with_valid: status got %h required 00", d); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      wr(A_CTRL, 8'h72);
      push(32'h12345678);
      rd(A_IRDATA, d);
      checks++; if (d !== 8'h78) begin errors++; $display("FAIL pre_reset_irdata: got %h required 78", d); end
      wr(A_WDATA, 8'h77);
      repeat (4) @(negedge clk); #1;
      checks++; if ({LCD_EN, irq, LCD_RS} !== 3'b111) begin
         errors++; $display("FAIL pre_reset_state: en/irq/rs got %b required 111", {LCD_EN, irq, LCD_RS}); end
      #2 reset = 1'b0; #1;
      checks++; if ({D_OUT, irq, LCD_BLON, LCD_DATA, LCD_EN, LCD_ON, LCD_RS, LCD_RW} !== 22'd0) begin
         errors++; $display("FAIL reset_mid_outputs: got %h required 0", {D_OUT, irq, LCD_BLON, LCD_DATA, LCD_EN, LCD_ON, LCD_RS, LCD_RW}); end
      @(posedge clk); reset = 1'b1;
      rd(A_STATUS, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_mid_fifo: status got %h required 00", d); end
      test_lcd_transfer(8'h3C);
   endtask

   initial begin
      test_reset();
      test_ctrl();
      test_lcd_transfer(8'h41);
      test_lcd_overrun();
      test_fifo();
      test_back_to_back();
      test_irq();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sfr_ir_lcd_fifo.md
Name: sfr_ir_lcd_fifo

Overview:
- Parametrised second-generation 8051 SFR peripheral combining IR code capture and the HD44780-style character LCD port.
- Captured IR codes are buffered in a FIFO instead of a single register, and SFR addresses are relocatable.
- LCD writes use a timed setup/strobe/hold sequencer with a busy flag, sticky error flags and an interrupt.
- Sits on the DW8051 SFR bus beside the IR receiver; drives the LCD pins directly.

Parameters:
SFR_BASE, 8'hD0, base SFR address; register offsets below are added to it
IR_BYTES, 4, bytes per captured IR code (1..8)
FIFO_DEPTH, 4, IR code FIFO entries (power of 2, 2..16)
LCD_SETUP_CYCLES, 2, clk cycles data/RS stable before EN rises (>=1)
LCD_EN_CYCLES, 32, clk cycles EN held high (>=1)

Ports:
clk  in  1  system clock; all state updates on the falling edge
reset  in  1  asynchronous active-low reset
addr  in  8  SFR address
D_IN  in  8  SFR write data
D_OUT  out  8  SFR read data (registered)
sfr_wr  in  1  SFR write strobe, one cycle
sfr_rd  in  1  SFR read strobe, one cycle
ir_valid  in  1  one-cycle pulse: ir_code holds a new decoded code
ir_code  in  8*IR_BYTES  decoded IR code; byte 0 in bits [7:0]
irq  out  1  interrupt, level, registered
LCD_BLON  out  1  backlight on
LCD_DATA  out  8  LCD data bus
LCD_EN  out  1  LCD enable strobe
LCD_ON  out  1  LCD power
LCD_RS  out  1  register select
LCD_RW  out  1  tied 0 (write-only interface)

Behaviour:
- Reset: all outputs 0; CTRL=0; BYTE_SEL=0; FIFO empty; sticky flags 0; LCD FSM IDLE.
- Register map (offset from SFR_BASE):
  - +1 CTRL (R/W):
    - bit4 LCD_ON, bit5 BLON, bit6 IRQ_EN.
    - bit1=1 sets RS; else bit0=1 clears RS; else RS holds. RS bits are not stored.
    - bit7 FLUSH is self-clearing: empties the FIFO and clears IR_OVF.
  - +3 LCD_WDATA (W): starts an LCD write.
  - +B STATUS (R): bit0 LCD_BUSY, bit1 FIFO_NE, bit2 FIFO_FULL, bit3 IR_OVF (sticky), bit4 LCD_OVR (sticky); other bits 0.
  - +C BYTE_SEL (R/W): low 3 bits used.
  - +D IR_DATA (R): byte BYTE_SEL of the FIFO head entry.
  - +E POP (W): any write removes the head entry.
- Outputs: LCD_ON, LCD_BLON and RS outputs are registered from CTRL, one cycle after the write.
- Read path:
  - D_OUT is updated on the falling edge on which sfr_rd is high and addr matches; otherwise it holds.
  - IR_DATA returns 0 when the FIFO is empty or BYTE_SEL >= IR_BYTES.
  - A STATUS read returns the current flags, then clears IR_OVF and LCD_OVR in the same edge. A flag set on that same edge wins over the clear.
- FIFO:
  - Push on ir_valid when not full.
  - ir_valid while full: code dropped, IR_OVF set.
  - Pop while empty: ignored.
  - Push and pop on the same edge: both take effect. At full, the pop frees a slot so the push succeeds with no overflow.
  - FLUSH together with ir_valid: flush wins, code dropped, IR_OVF not set.
  - Pointers wrap modulo FIFO_DEPTH; count is one bit wider than the pointer.
- LCD FSM, states IDLE -> SETUP -> PULSE -> HOLD -> IDLE:
  - Write to LCD_WDATA in IDLE: latch LCD_DATA=D_IN, enter SETUP with EN=0.
  - SETUP lasts LCD_SETUP_CYCLES cycles, then PULSE.
  - PULSE holds EN=1 for exactly LCD_EN_CYCLES cycles, then HOLD.
  - HOLD lasts 1 cycle with EN=0, then IDLE.
  - LCD_BUSY = (state != IDLE).
  - Write to LCD_WDATA while busy: ignored (LCD_DATA unchanged), LCD_OVR set.
  - A CTRL RS change during a transfer is deferred until IDLE.
- irq = IRQ_EN & (FIFO_NE | IR_OVF), registered, so it asserts one cycle after its cause.
- Reset asserted mid-transfer: EN drops to 0 immediately and the FSM returns to IDLE; FIFO contents are lost.
- Unmapped addresses: writes have no effect; reads leave D_OUT unchanged.

Decomposition:
- Shared package holds:
  - offset constants CTRL_OFS=1, LCD_WDATA_OFS=3, STATUS_OFS=8'hB, BYTE_SEL_OFS=8'hC, IR_DATA_OFS=8'hD, POP_OFS=8'hE
  - STATUS bit indices
  - LCD FSM state encoding
- One sub-module: ir_code_fifo (parametrised width/depth, push/pop/flush, full/empty/count, combinational head output).

Test Plan:
- Write CTRL=8'h32 -> next cycle LCD_ON=1, BLON=1, RS=1. Then write CTRL=8'h31 -> RS=0, LCD_ON=1.
- Write LCD_WDATA=8'h41 -> LCD_DATA=41; EN low for 2 cycles, high for exactly 32, low; STATUS bit0=1 throughout, 0 after HOLD. A second write of 8'h42 mid-pulse -> LCD_DATA stays 41, STATUS bit4=1, then 0 after that read.
- Push 5 codes 0x11223344..0x55667788 with depth 4 -> FULL=1, IR_OVF=1. BYTE_SEL=3, read IR_DATA -> 8'h11. POP four times -> FIFO_NE=0, IR_DATA reads 0.
- FIFO full, then POP write and ir_valid on the same edge -> still FULL, IR_OVF=0, new code at tail.
- IRQ_EN=1, one code pushed -> irq=1 one cycle later. FLUSH -> FIFO empty and irq=0.
- Assert reset during PULSE -> EN=0 immediately, all outputs 0. After release, a new LCD write runs the full sequence.
